lcd_write_sequencer: RTL and testbench
======================================

# lcd_write_sequencer

Sequencer and arbiter for the 16x2 HD44780 character LCD. It runs the power-on initialisation sequence, then accepts single-byte command/data writes from two requesters through a valid/ready handshake, arbitrated round-robin. It drives the LCD bus with the required setup, enable-pulse, hold and execution-wait timing. It sits between the message sources (CPU trace message path and switch hex display path) and the LCD pins; the top level ties LCD_ON/LCD_BLON high and connects LCD_DATA as an output-only bus.

## Interface
Parameters (all in CLOCK_50 cycles):
- T_PWR, 750000: power-up wait before the first init command (15 ms).
- T_SETUP, 2: RS/DATA setup before EN rises (40 ns).
- T_EN, 12: EN high width (240 ns).
- T_HOLD, 2: RS/DATA hold after EN falls.
- T_EXEC, 2000: execution wait for normal commands and data (40 us).
- T_LONG, 82000: execution wait for clear/home (1.64 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 write request.
- req0_rs  in  1  requester 0 register select: 0 = command, 1 = data.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 accept.
- req1_valid, req1_rs, req1_data, req1_ready: same as requester 0, for requester 1.
- init_done  out  1  init sequence complete; sticky until reset.
- busy  out  1  high whenever the state is not IDLE.
- LCD_RS  out  1  command/data select.
- LCD_RW  out  1  constant 0 (write-only).
- LCD_EN  out  1  enable strobe.
- LCD_DATA  out  8  data bus.

## Operation
- States: PWR_WAIT, INIT_LOAD, SETUP, EN_HIGH, HOLD, EXEC_WAIT, IDLE.
- PWR_WAIT:
  - Count T_PWR cycles, then go to INIT_LOAD.
  - Init sequence, all with RS=0: 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry mode increment).
  - The init index advances after each EXEC_WAIT. After the 4th byte: init_done=1, go to IDLE.
- IDLE:
  - reqN_ready = IDLE && init_done && grant==N. This is combinational from registered state and valid.
  - A transfer is accepted when valid && ready in the same cycle. Accepted RS/data are latched; the next state is SETUP.
- Arbitration:
  - Round-robin on a last_served pointer.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_served is granted.
  - Neither valid: no grant, and the pointer is unchanged.
  - The pointer updates on accept only.
- Bus sequence:
  - SETUP: EN=0, RS and DATA driven from the latch, for T_SETUP cycles.
  - EN_HIGH: EN=1 for T_EN cycles.
  - HOLD: EN=0, RS/DATA unchanged, for T_HOLD cycles.
  - EXEC_WAIT: wait T_LONG if RS==0 && data[7:2]==0 && data[1:0]!=0 (clear/home); otherwise wait T_EXEC.
  - RS/DATA keep their last value until the next SETUP.
- Requests arriving before init_done are held off (ready=0). No requests are dropped; requesters must hold valid and payload stable until accepted.
- Reset, including mid-operation:
  - All registers are cleared asynchronously. EN=0 immediately.
  - The sequence restarts at PWR_WAIT with init_done=0 and last_served=1, so requester 0 wins the first tie.

## Timing
- Reset values: LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, req0_ready=0, req1_ready=0, init_done=0, busy=1.
- Accept at cycle k:
  - SETUP starts at k+1.
  - EN rises at k+1+T_SETUP.
  - EN falls at k+1+T_SETUP+T_EN.
  - EXEC_WAIT starts at k+1+T_SETUP+T_EN+T_HOLD.
  - IDLE is reached, and ready may rise, at k+1+T_SETUP+T_EN+T_HOLD+T_wait.
- Back-to-back throughput is one byte per 1+T_SETUP+T_EN+T_HOLD+T_wait cycles.
- init_done rises in the same cycle the FSM first enters IDLE.
- The timer is a single down-counter. Its width is $clog2(max parameter)+1. It is loaded with N-1 on state entry; the state exits when the count reaches 0.

## Structure
- Shared header lcd_defs.vh holds:
  - state encodings;
  - init command constants LCD_CMD_FUNC=0x38, LCD_CMD_DISP=0x0C, LCD_CMD_CLEAR=0x01, LCD_CMD_ENTRY=0x06;
  - INIT_LEN=4.
- One sub-module, lcd_timer: a loadable down-counter with a load value and load input, and a registered done output. The FSM, arbiter and latch live in the top module.

## Test plan
Bench parameters: T_PWR=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_LONG=30.
- Reset release -> EN pulses exactly 4 times with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. The gap after 0x01 uses 30 wait cycles. init_done rises afterwards; ready is 0 throughout.
- After init, req0 writes RS=1, data 0x41 -> EN high for 4 cycles starting 3 cycles after accept. DATA=0x41, RS=1 stable from SETUP through HOLD. ready returns 19 cycles after accept.
- req1 sends command 0x01 -> EXEC_WAIT lasts 30 cycles. Command 0x80 -> 10 cycles.
- req0 and req1 both held valid for 4 transfers -> accept order is 0, 1, 0, 1.
- req0 valid before init_done -> no accept until init_done. The first accepted byte is req0's, unchanged.
- Assert reset while EN is high -> EN=0 in the same cycle, init_done=0, and the full init sequence replays.

Source files
------------

// File: rtl/lcd_write_sequencer_pkg.sv
// rtl/lcd_write_sequencer_pkg.sv - shared state encodings, HD44780 init commands and helpers
package lcd_write_sequencer_pkg;

    localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
    localparam logic [2:0] ST_INIT_LOAD = 3'd1;
    localparam logic [2:0] ST_SETUP     = 3'd2;
    localparam logic [2:0] ST_EN_HIGH   = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
    localparam logic [2:0] ST_EXEC_WAIT = 3'd5;
    localparam logic [2:0] ST_IDLE      = 3'd6;

    localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
    localparam int         INIT_LEN      = 4;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNC;
            2'd1:    return LCD_CMD_DISP;
            2'd2:    return LCD_CMD_CLEAR;
            default: return LCD_CMD_ENTRY;
        endcase
    endfunction

    // Clear display and return home need the long execution wait.
    function automatic logic is_long_cmd(input lcd_byte_t b);
        return !b.rs && (b.data[7:2] == 6'd0) && (b.data[1:0] != 2'd0);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_timer.sv
// rtl/lcd_write_sequencer_timer.sv - loadable down-counter with registered done flag
module lcd_timer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    // done_q tracks (cnt_q == 0) so the FSM sees it without a compare path.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (load_i) begin
            cnt_d  = load_val_i;
            done_d = (load_val_i == '0);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - W'(1);
            done_d = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= RESET_VAL;
            done_q <= (RESET_VAL == '0);
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 init sequencer, two-port round-robin write arbiter and bus timing
module lcd_write_sequencer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int T_PWR   = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    localparam int T_MAX = max_of(max_of(max_of(T_PWR, T_SETUP), max_of(T_EN, T_HOLD)),
                                  max_of(T_EXEC, T_LONG));
    localparam int TW    = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] LD_PWR   = TW'(T_PWR - 1);
    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
    localparam logic [TW-1:0] LD_LONG  = TW'(T_LONG - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic          init_done_q, init_done_d;
    logic          last_q, last_d;
    lcd_byte_t     byte_q, byte_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic          gnt0, gnt1, can_accept, acc0, acc1;

    // A lone requester always wins; on a tie the one not served last wins.
    assign gnt0       = req0_valid && (!req1_valid || last_q);
    assign gnt1       = req1_valid && (!req0_valid || !last_q);
    assign can_accept = (state_q == ST_IDLE) && init_done_q;
    assign req0_ready = can_accept && gnt0;
    assign req1_ready = can_accept && gnt1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    lcd_timer #(
        .W         (TW),
        .RESET_VAL (LD_PWR)
    ) u_timer (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        last_d      = last_q;
        byte_d      = byte_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            ST_PWR_WAIT: begin
                if (tmr_done) state_d = ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
                byte_d   = '{rs: 1'b0, data: init_cmd(init_idx_q)};
                state_d  = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = LD_SETUP;
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_EN_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            ST_EN_HIGH: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d  = ST_EXEC_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(byte_q) ? LD_LONG : LD_EXEC;
                end
            end
            ST_EXEC_WAIT: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (init_idx_q == 2'(INIT_LEN - 1)) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = ST_INIT_LOAD;
                    end
                end
            end
            ST_IDLE: begin
                if (acc0 || acc1) begin
                    byte_d   = acc0 ? '{rs: req0_rs, data: req0_data}
                                    : '{rs: req1_rs, data: req1_data};
                    last_d   = acc1;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            default: begin
                state_d  = ST_PWR_WAIT;
                tmr_load = 1'b1;
                tmr_val  = LD_PWR;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PWR_WAIT;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            last_q      <= 1'b1;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            last_q      <= last_d;
            byte_q      <= byte_d;
        end
    end

    // EN decodes straight from state so an asynchronous reset drops it at once.
    assign LCD_EN    = (state_q == ST_EN_HIGH);
    assign LCD_RW    = 1'b0;
    assign LCD_RS    = byte_q.rs;
    assign LCD_DATA  = byte_q.data;
    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - randomized scoreboard bench for lcd_write_sequencer
`timescale 1ns/1ps
module tb_lcd_write_sequencer;

    localparam int T_PWR = 20, T_SETUP = 2, T_EN = 4, T_HOLD = 2, T_EXEC = 10, T_LONG = 30;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       init_done, busy, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    lcd_write_sequencer #(
        .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_LONG(T_LONG)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .init_done(init_done), .busy(busy),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wt;
        bit         init_after;
        bit         idle_after;
        bit         chk_acc;
    } exp_t;

    exp_t       exp_q[$];
    bit         exp_who[$];
    logic [8:0] pend0[$], pend1[$];
    logic [7:0] init_seq[4];
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    bit         model_last = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int exec_time(input logic rs, input logic [7:0] d);
        if (!rs && d >= 8'd1 && d <= 8'd3) return T_LONG;
        return T_EXEC;
    endfunction

    task automatic push_init();
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{1'b0, init_seq[i], exec_time(1'b0, init_seq[i]), i == 3, i == 3, 1'b0});
    endtask

    // Round-robin model: both pending -> the one not served last; else whoever is pending.
    task automatic issue_batch(input logic [8:0] b0[$], input logic [8:0] b1[$]);
        int i0 = 0, i1 = 0;
        bit pick;
        logic [8:0] it;
        while (i0 < b0.size() || i1 < b1.size()) begin
            if (i0 < b0.size() && i1 < b1.size()) pick = !model_last;
            else pick = (i0 < b0.size()) ? 1'b0 : 1'b1;
            it = pick ? b1[i1] : b0[i0];
            if (pick) i1++; else i0++;
            exp_q.push_back('{it[8], it[7:0], exec_time(it[8], it[7:0]), 1'b1, 1'b1, 1'b1});
            exp_who.push_back(pick);
            model_last = pick;
        end
        foreach (b0[i]) pend0.push_back(b0[i]);
        foreach (b1[i]) pend1.push_back(b1[i]);
    endtask

    function automatic logic [8:0] rand_item();
        if ($urandom_range(0, 3) == 0) return {1'b0, 8'($urandom_range(1, 3))};
        return 9'($urandom);
    endfunction

    // Requester drivers: hold valid/payload until the handshake is seen.
    bit acc0, acc1;
    initial begin
        req0_valid = 0; req0_rs = 0; req0_data = 0;
        forever begin
            @(negedge CLOCK_50);
            acc0 = req0_valid && req0_ready && !reset;
            @(posedge CLOCK_50); #1;
            if (acc0 && pend0.size() > 0) void'(pend0.pop_front());
            if (pend0.size() > 0) begin req0_valid = 1; {req0_rs, req0_data} = pend0[0]; end
            else req0_valid = 0;
        end
    end
    initial begin
        req1_valid = 0; req1_rs = 0; req1_data = 0;
        forever begin
            @(negedge CLOCK_50);
            acc1 = req1_valid && req1_ready && !reset;
            @(posedge CLOCK_50); #1;
            if (acc1 && pend1.size() > 0) void'(pend1.pop_front());
            if (pend1.size() > 0) begin req1_valid = 1; {req1_rs, req1_data} = pend1[0]; end
            else req1_valid = 0;
        end
    end

    // Monitor: pops the scoreboard on each EN pulse and on each accept.
    bit   en_prev = 0, tracking = 0, have_cur = 0;
    int   rise_cyc = 0, fall_cyc = 0, acc_cyc = 0, d = 0;
    exp_t cur;
    always @(negedge CLOCK_50) begin
        cyc++;
        if (reset) begin
            en_prev = 0; tracking = 0; have_cur = 0;
        end else begin
            check("rw_low", LCD_RW, 0);
            check("ready_legal", ((req0_ready || req1_ready) && (busy || !init_done)) ||
                                 (req0_ready && req1_ready), 0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cyc = cyc;
                if (exp_who.size() == 0) check("accept_unexpected", 1, 0);
                else check("accept_who", req1_valid && req1_ready, exp_who.pop_front());
            end
            if (LCD_EN && !en_prev) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("en_unexpected", 1, 0);
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    check("data", LCD_DATA, cur.data);
                    check("rs", LCD_RS, cur.rs);
                    if (cur.chk_acc) check("accept_to_en", cyc - acc_cyc, T_SETUP + 1);
                end
            end
            if (!LCD_EN && en_prev) begin
                check("en_width", cyc - rise_cyc, T_EN);
                fall_cyc = cyc;
                tracking = have_cur;
            end
            if (have_cur && (LCD_EN || (tracking && cyc - fall_cyc < T_HOLD)))
                check("bus_stable", {LCD_RS, LCD_DATA}, {cur.rs, cur.data});
            if (tracking) begin
                d = cyc - fall_cyc;
                if (d == T_HOLD + cur.wt - 1) check("busy_in_exec", busy, 1);
                if (d == T_HOLD + cur.wt) begin
                    check("idle_after_wait", !busy, cur.idle_after);
                    check("init_done_after", init_done, cur.init_after);
                    tracking = 0;
                end
            end
            en_prev = LCD_EN;
        end
    end

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_who.size() != 0 || tracking || busy ||
                pend0.size() != 0 || pend1.size() != 0) && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("wait_quiet_timeout", n >= budget, 0);
        repeat ($urandom_range(1, 4)) @(negedge CLOCK_50);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, LCD_EN, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    logic [8:0] b0[$], b1[$];
    initial begin
        int n;
        init_seq[0] = 8'h38; init_seq[1] = 8'h0C; init_seq[2] = 8'h01; init_seq[3] = 8'h06;
        push_init();
        b0.delete(); b1.delete();
        b0.push_back(rand_item());
        issue_batch(b0, b1);
        @(negedge CLOCK_50);
        check_reset_outputs("rst");
        check("rst_rs", LCD_RS, 0);
        check("rst_data", LCD_DATA, 8'h00);
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 0;
        wait_quiet(1500);

        b0.delete(); b1.delete(); b0.push_back({1'b1, 8'h41}); issue_batch(b0, b1); wait_quiet(200);
        b0.delete(); b1.delete(); b1.push_back({1'b0, 8'h01}); issue_batch(b0, b1); wait_quiet(200);
        b0.delete(); b1.delete(); b1.push_back({1'b0, 8'h80}); issue_batch(b0, b1); wait_quiet(200);
        b0.delete(); b1.delete();
        b0.push_back({1'b1, 8'h30}); b0.push_back({1'b1, 8'h31});
        b1.push_back({1'b1, 8'h50}); b1.push_back({1'b1, 8'h51});
        issue_batch(b0, b1); wait_quiet(400);

        repeat (10) begin
            b0.delete(); b1.delete();
            n = $urandom_range(0, 3); repeat (n) b0.push_back(rand_item());
            n = $urandom_range(0, 3); repeat (n) b1.push_back(rand_item());
            issue_batch(b0, b1);
            wait_quiet(600);
        end

        b0.delete(); b1.delete(); b0.push_back(rand_item()); issue_batch(b0, b1);
        n = 0;
        while (!LCD_EN && n < 200) begin @(negedge CLOCK_50); n++; end
        check("wait_en_timeout", n >= 200, 0);
        #1 reset = 1;
        #1 check_reset_outputs("midrst");
        exp_q.delete(); exp_who.delete(); pend0.delete(); pend1.delete();
        model_last = 1'b1;
        push_init();
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 0;
        wait_quiet(1500);

        b0.delete(); b1.delete();
        b0.push_back(rand_item()); b1.push_back(rand_item());
        issue_batch(b0, b1);
        wait_quiet(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
